// File: rtl/psimd_pkg.sv
// -----------------------------------------------------------------------------
// psimd_pkg
//
// Shared types and constants for the PSIMD DLFloat writeback path.
//   - Exception flag bit positions inside the 5-bit {NV,DZ,OF,UF,NX} vector.
//   - wb_state_t : writeback FSM states.
//   - wb_entry_t : one queued result, as captured from the execution unit.
//   - wb_hi_t    : the part of a wide entry that is still needed for its
//                  second (high) register write.
//   - Helpers that build the halfword write masks of a wide result and
//     OR-reduce per-lane flags over the committed lanes.
//
// The struct field widths use the WB_* constants below; the top-level
// parameters of psimd_writeback_unit must keep their default values so that
// port widths and struct fields line up.
// -----------------------------------------------------------------------------
package psimd_pkg;

   localparam int LANE_W        = 16;
   localparam int WB_REG_WIDTH  = 64;
   localparam int WB_NUM_LANES  = 4;
   localparam int WB_ADDR_WIDTH = 5;
   localparam int NUM_FLAGS     = 5;

   // Flag bit positions, also the index order of wb_entry_t.flags.
   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2
   } wb_state_t;

   typedef logic [WB_NUM_LANES-1:0] lane_vec_t;

   typedef struct packed {
      logic                          wide;
      logic [WB_ADDR_WIDTH-1:0]      rd;
      lane_vec_t                     mask;
      logic [WB_REG_WIDTH-1:0]       data;
      logic [WB_REG_WIDTH-1:0]       datai_0;
      logic [WB_REG_WIDTH-1:0]       datai_1;
      lane_vec_t [NUM_FLAGS-1:0]     flags;   // flags[FLAG_xx][lane]
   } wb_entry_t;

   typedef struct packed {
      logic [WB_ADDR_WIDTH-1:0]      rd;
      lane_vec_t                     mask;
      logic [WB_REG_WIDTH-1:0]       datai_1;
      lane_vec_t [NUM_FLAGS-1:0]     flags;
   } wb_hi_t;

   // Integer lanes 0/1 each span two halfwords of the low register.
   function automatic lane_vec_t lo_mask(input lane_vec_t m);
      return {m[1], m[1], m[0], m[0]};
   endfunction

   // Integer lanes 2/3 each span two halfwords of the high register.
   function automatic lane_vec_t hi_mask(input lane_vec_t m);
      return {m[3], m[3], m[2], m[2]};
   endfunction

   // One bit per flag class: set when any committed lane raised it.
   function automatic logic [NUM_FLAGS-1:0] reduce_flags(
      input lane_vec_t [NUM_FLAGS-1:0] f,
      input lane_vec_t                 m
   );
      logic [NUM_FLAGS-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_FLAGS; i++) begin
         r[i] = |(f[i] & m);
      end
      return r;
   endfunction

endpackage

// File: rtl/psimd_wb_fifo.sv
// -----------------------------------------------------------------------------
// psimd_wb_fifo
//
// Small synchronous FIFO holding writeback entries that arrive while the
// writeback FSM is occupied.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  enqueue request and data (ignored when full)
//   pop          dequeue request (ignored when empty)
//   rdata        head entry, valid while !empty
//   full, empty  occupancy status, decoded from a registered count
// -----------------------------------------------------------------------------
module psimd_wb_fifo #(
   parameter int DEPTH = 2,   // power of two, >= 2
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; an entry is only read after
   // it was written, and leaving it out of reset keeps it plain RAM/flops.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/psimd_writeback_unit.sv
// -----------------------------------------------------------------------------
// psimd_writeback_unit
//
// Retires packed 4-lane DLFloat results (and 128-bit integer-conversion
// results as two consecutive writes) into the vector register file through a
// single write port, and accumulates exception flags into sticky fflags.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      result handshake; in_ready = FIFO not full
//   in_wide                  1: integer pair in_datai_0/1, 0: packed in_data
//   in_rd, in_lane_mask      destination register and committed lanes
//   in_data, in_datai_0/1    result payloads
//   in_nv/nx/of/uf/dz        per-lane exception flags
//   rf_we/waddr/wdata/wmask  registered register-file write port
//   fflags, fflags_clr       sticky {NV,DZ,OF,UF,NX} and its clear
//   busy                     FIFO non-empty or FSM not IDLE
//   lane_fflags              (PSIMD_WB_LANE_FLAGS_EN only) per-lane sticky flags
//
// Build option:
//   PSIMD_WB_LANE_FLAGS_EN   adds the lane_fflags output and its registers.
//
// An entry arriving while the FIFO is empty and the FSM can start new work
// bypasses the FIFO, so its first write is visible the cycle after it is
// accepted. state_q names the write currently shown on rf_*.
// -----------------------------------------------------------------------------
module psimd_writeback_unit
   import psimd_pkg::*;
#(
   parameter int REG_WIDTH  = 64,
   parameter int NUM_LANES  = 4,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_wide,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic [NUM_LANES-1:0]  in_lane_mask,
   input  logic [REG_WIDTH-1:0]  in_data,
   input  logic [REG_WIDTH-1:0]  in_datai_0,
   input  logic [REG_WIDTH-1:0]  in_datai_1,
   input  logic [NUM_LANES-1:0]  in_nv,
   input  logic [NUM_LANES-1:0]  in_nx,
   input  logic [NUM_LANES-1:0]  in_of,
   input  logic [NUM_LANES-1:0]  in_uf,
   input  logic [NUM_LANES-1:0]  in_dz,
   output logic                  rf_we,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [REG_WIDTH-1:0]  rf_wdata,
   output logic [NUM_LANES-1:0]  rf_wmask,
   output logic [4:0]            fflags,
   input  logic                  fflags_clr,
   output logic                  busy
`ifdef PSIMD_WB_LANE_FLAGS_EN
   ,
   output logic [5*NUM_LANES-1:0] lane_fflags
`endif
);

   wb_entry_t in_entry, fifo_rdata, head;
   wb_hi_t    hi_q, hi_d;
   wb_state_t state_q, state_d;
   logic      cur_wide_q, cur_wide_d;

   logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic      accept, head_valid, can_take, take;

   logic                  rf_we_q, rf_we_d;
   logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [REG_WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
   logic [NUM_LANES-1:0]  rf_wmask_q, rf_wmask_d;
   logic [NUM_FLAGS-1:0]  fflags_q, fflags_d, new_flags;

   // Flags of the entry whose last write is being launched this cycle.
   logic                      merge_en;
   lane_vec_t [NUM_FLAGS-1:0] merge_flags;
   lane_vec_t                 merge_mask;

   // ---------------------------------------------------------------- input
   always_comb begin
      in_entry               = '0;
      in_entry.wide          = in_wide;
      in_entry.rd            = in_rd;
      in_entry.mask          = in_lane_mask;
      in_entry.data          = in_data;
      in_entry.datai_0       = in_datai_0;
      in_entry.datai_1       = in_datai_1;
      in_entry.flags[FLAG_NV] = in_nv;
      in_entry.flags[FLAG_DZ] = in_dz;
      in_entry.flags[FLAG_OF] = in_of;
      in_entry.flags[FLAG_UF] = in_uf;
      in_entry.flags[FLAG_NX] = in_nx;
   end

   // Ready depends only on registered occupancy (and reset), never on in_valid.
   assign in_ready = !rst && !fifo_full;
   assign accept   = in_valid && in_ready;

   // Only the low half of a wide entry blocks new work; every other state is
   // either idle or finishing its entry this cycle.
   assign can_take   = !((state_q == WR_LO) && cur_wide_q);
   assign head_valid = !fifo_empty || accept;
   assign head       = fifo_empty ? in_entry : fifo_rdata;
   assign take       = can_take && head_valid;
   assign fifo_pop   = take && !fifo_empty;
   assign fifo_push  = accept && !(take && fifo_empty);

   psimd_wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(wb_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (in_entry),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // ------------------------------------------------------ FSM / write port
   // NOTE: every signal written here gets a default first, so no path
   // through the block leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = IDLE;
      cur_wide_d  = cur_wide_q;
      hi_d        = hi_q;
      rf_waddr_d  = rf_waddr_q;
      rf_wdata_d  = rf_wdata_q;
      rf_wmask_d  = rf_wmask_q;
      merge_en    = 1'b0;
      merge_flags = '0;
      merge_mask  = '0;

      if (!can_take) begin
         // Second half of a wide result; address wraps at the top register.
         state_d     = WR_HI;
         cur_wide_d  = 1'b0;
         rf_waddr_d  = hi_q.rd + WB_ADDR_WIDTH'(1);
         rf_wdata_d  = hi_q.datai_1;
         rf_wmask_d  = hi_mask(hi_q.mask);
         merge_en    = 1'b1;
         merge_flags = hi_q.flags;
         merge_mask  = hi_q.mask;
      end else if (head_valid) begin
         state_d    = WR_LO;
         cur_wide_d = head.wide;
         rf_waddr_d = head.rd;
         hi_d.rd      = head.rd;
         hi_d.mask    = head.mask;
         hi_d.datai_1 = head.datai_1;
         hi_d.flags   = head.flags;
         if (head.wide) begin
            rf_wdata_d = head.datai_0;
            rf_wmask_d = lo_mask(head.mask);
         end else begin
            rf_wdata_d  = head.data;
            rf_wmask_d  = head.mask;
            merge_en    = 1'b1;
            merge_flags = head.flags;
            merge_mask  = head.mask;
         end
      end

      // A zero-mask write still uses its cycle but does not strobe.
      rf_we_d   = (state_d != IDLE) && (rf_wmask_d != '0);
      new_flags = merge_en ? reduce_flags(merge_flags, merge_mask) : '0;
      // Clear and merge in the same cycle leave only the new flags.
      fflags_d  = (fflags_clr ? '0 : fflags_q) | new_flags;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_wide_q <= 1'b0;
         hi_q       <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         rf_wmask_q <= '0;
         fflags_q   <= '0;
      end else begin
         state_q    <= state_d;
         cur_wide_q <= cur_wide_d;
         hi_q       <= hi_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         rf_wmask_q <= rf_wmask_d;
         fflags_q   <= fflags_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign rf_wmask = rf_wmask_q;
   assign fflags   = fflags_q;
   assign busy     = !fifo_empty || (state_q != IDLE);

`ifdef PSIMD_WB_LANE_FLAGS_EN
   // Per-lane sticky flags; lane l occupies bits [5*l +: 5] as {NV,DZ,OF,UF,NX}.
   logic [NUM_FLAGS*NUM_LANES-1:0] lane_fflags_q, lane_fflags_d, new_lane_flags;

   always_comb begin
      new_lane_flags = '0;
      if (merge_en) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            for (int f = 0; f < NUM_FLAGS; f++) begin
               new_lane_flags[l*NUM_FLAGS+f] = merge_flags[f][l] & merge_mask[l];
            end
         end
      end
      lane_fflags_d = (fflags_clr ? '0 : lane_fflags_q) | new_lane_flags;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_fflags_q <= '0;
      end else begin
         lane_fflags_q <= lane_fflags_d;
      end
   end

   assign lane_fflags = lane_fflags_q;
`endif

endmodule

// File: tb/tb_psimd_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_psimd_writeback_unit
//
// Bench for psimd_writeback_unit. A reference model expands every accepted
// entry into its register writes (one for narrow, two for wide) and retires
// one write per cycle; fflags and occupancy follow from that write stream.
// Directed scenarios pin literal values, then randomized traffic runs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_psimd_writeback_unit;

   localparam int REG_WIDTH  = 64;
   localparam int NUM_LANES  = 4;
   localparam int ADDR_WIDTH = 5;
   localparam int DEPTH      = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid, in_ready, in_wide;
   logic [ADDR_WIDTH-1:0] in_rd;
   logic [NUM_LANES-1:0]  in_lane_mask;
   logic [REG_WIDTH-1:0]  in_data, in_datai_0, in_datai_1;
   logic [NUM_LANES-1:0]  in_nv, in_nx, in_of, in_uf, in_dz;
   logic                  rf_we;
   logic [ADDR_WIDTH-1:0] rf_waddr;
   logic [REG_WIDTH-1:0]  rf_wdata;
   logic [NUM_LANES-1:0]  rf_wmask;
   logic [4:0]            fflags;
   logic                  fflags_clr;
   logic                  busy;
`ifdef PSIMD_WB_LANE_FLAGS_EN
   logic [5*NUM_LANES-1:0] lane_fflags;
`endif

   psimd_writeback_unit #(
      .REG_WIDTH  (REG_WIDTH),
      .NUM_LANES  (NUM_LANES),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_wide      (in_wide),
      .in_rd        (in_rd),
      .in_lane_mask (in_lane_mask),
      .in_data      (in_data),
      .in_datai_0   (in_datai_0),
      .in_datai_1   (in_datai_1),
      .in_nv        (in_nv),
      .in_nx        (in_nx),
      .in_of        (in_of),
      .in_uf        (in_uf),
      .in_dz        (in_dz),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .rf_wmask     (rf_wmask),
      .fflags       (fflags),
      .fflags_clr   (fflags_clr),
      .busy         (busy)
`ifdef PSIMD_WB_LANE_FLAGS_EN
      ,
      .lane_fflags  (lane_fflags)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ model
   typedef struct {
      logic [ADDR_WIDTH-1:0] addr;
      logic [REG_WIDTH-1:0]  data;
      logic [NUM_LANES-1:0]  mask;
      bit                    first;   // first write of its entry
      bit                    last;    // last write: merges the entry's flags
      logic [4:0]            flags;
      logic [5*NUM_LANES-1:0] lane;
   } slot_t;

   slot_t                  q[$];
   bit                     model_ok = 0;
   logic                   m_we, m_vis;
   logic [ADDR_WIDTH-1:0]  m_addr;
   logic [REG_WIDTH-1:0]   m_data;
   logic [NUM_LANES-1:0]   m_mask;
   logic [4:0]             m_fflags;
   logic [5*NUM_LANES-1:0] m_lane;
   int                     we_seen = 0;

   // Lane l of a flag vector contributes only if lane l is committed.
   function automatic logic [4:0] lane_bits(input int l);
      if (!in_lane_mask[l]) return 5'b0;
      return {in_nv[l], in_dz[l], in_of[l], in_uf[l], in_nx[l]};
   endfunction

   always @(negedge clk) begin : model_p
      int waiting;
      slot_t s, s2;
      logic [4:0] fl;
      logic [5*NUM_LANES-1:0] ln;

      waiting = 0;
      foreach (q[i]) if (q[i].first) waiting++;

      if (model_ok) begin
         check("rf_we", rf_we, m_we);
         check("rf_waddr", rf_waddr, m_addr);
         check("rf_wdata", rf_wdata, m_data);
         check("rf_wmask", rf_wmask, m_mask);
         check("fflags", fflags, m_fflags);
         check("busy", busy, (waiting > 0) || m_vis);
         check("in_ready", in_ready, !rst && (waiting < DEPTH));
`ifdef PSIMD_WB_LANE_FLAGS_EN
         check("lane_fflags", lane_fflags, m_lane);
         check("fflags_or", fflags, lane_fflags[4:0] | lane_fflags[9:5] | lane_fflags[14:10] | lane_fflags[19:15]);
`endif
         if (rf_we === 1'b1) we_seen++;
      end

      if (rst) begin
         q.delete();
         m_we = 0; m_vis = 0; m_addr = '0; m_data = '0; m_mask = '0;
         m_fflags = '0; m_lane = '0;
         model_ok = 1;
      end else if (model_ok) begin
         if (in_valid && (waiting < DEPTH)) begin
            fl = '0;
            ln = '0;
            for (int l = 0; l < NUM_LANES; l++) begin
               fl = fl | lane_bits(l);
               ln[5*l +: 5] = lane_bits(l);
            end
            if (!in_wide) begin
               s.addr = in_rd; s.data = in_data; s.mask = in_lane_mask;
               s.first = 1; s.last = 1; s.flags = fl; s.lane = ln;
               q.push_back(s);
            end else begin
               // Integer lane k covers halfwords 2k and 2k+1 of its register.
               s.addr = in_rd; s.data = in_datai_0; s.first = 1; s.last = 0;
               s.flags = '0; s.lane = '0;
               s2.addr = ADDR_WIDTH'(in_rd + 1); s2.data = in_datai_1;
               s2.first = 0; s2.last = 1; s2.flags = fl; s2.lane = ln;
               for (int h = 0; h < NUM_LANES; h++) begin
                  s.mask[h]  = in_lane_mask[h/2];
                  s2.mask[h] = in_lane_mask[2 + h/2];
               end
               q.push_back(s);
               q.push_back(s2);
            end
         end
         if (fflags_clr) begin
            m_fflags = '0;
            m_lane   = '0;
         end
         m_we  = 0;
         m_vis = 0;
         if (q.size() > 0) begin
            s = q.pop_front();
            m_vis  = 1;
            m_we   = (s.mask != '0);
            m_addr = s.addr; m_data = s.data; m_mask = s.mask;
            if (s.last) begin
               m_fflags = m_fflags | s.flags;
               m_lane   = m_lane | s.lane;
            end
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic clear_inputs();
      in_valid = 0; in_wide = 0; in_rd = '0; in_lane_mask = '0;
      in_data = '0; in_datai_0 = '0; in_datai_1 = '0;
      in_nv = '0; in_nx = '0; in_of = '0; in_uf = '0; in_dz = '0;
      fflags_clr = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic set_entry(input logic wide, input logic [4:0] rd, input logic [3:0] mask,
                            input logic [63:0] d, input logic [63:0] d0, input logic [63:0] d1,
                            input logic [3:0] nv, input logic [3:0] dz, input logic [3:0] nx);
      in_wide = wide; in_rd = rd; in_lane_mask = mask;
      in_data = d; in_datai_0 = d0; in_datai_1 = d1;
      in_nv = nv; in_dz = dz; in_nx = nx; in_of = '0; in_uf = '0;
   endtask

   // Offer for exactly one cycle; caller guarantees in_ready is high.
   task automatic send();
      in_valid = 1;
      next_cycle();
      in_valid = 0;
   endtask

   task automatic drain(input string name);
      bit idle;
      idle = 0;
      for (int w = 0; w < 50 && !idle; w++) begin
         mid();
         idle = (busy === 1'b0);
         next_cycle();
      end
      check(name, idle, 1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit acc, saw_block;
      int we_start;

      clear_inputs();
      rst = 1;
      repeat (3) next_cycle();
      mid();
      check("reset_rf_we", rf_we, 0);
      check("reset_waddr", rf_waddr, 0);
      check("reset_wdata", rf_wdata, 0);
      check("reset_wmask", rf_wmask, 0);
      check("reset_fflags", fflags, 0);
      check("reset_busy", busy, 0);
      check("reset_in_ready", in_ready, 0);
      next_cycle();
      rst = 0;
      mid();
      check("ready_after_reset", in_ready, 1);
      next_cycle();

      // Narrow entry: write visible one cycle after acceptance.
      set_entry(0, 5'd3, 4'b1111, 64'h1111_2222_3333_4444, '0, '0, '0, '0, '0);
      send();
      mid();
      check("n_we", rf_we, 1);
      check("n_waddr", rf_waddr, 3);
      check("n_wdata", rf_wdata, 64'h1111_2222_3333_4444);
      check("n_wmask", rf_wmask, 4'b1111);
      next_cycle();
      mid();
      check("n_busy_low", busy, 0);
      next_cycle();

      // Wide entry at the top register: high write wraps to register 0.
      set_entry(1, 5'd31, 4'b0110, '0, 64'hAAAA_0000_AAAA_0001, 64'hBBBB_0000_BBBB_0002, '0, '0, '0);
      send();
      mid();
      check("w_lo_we", rf_we, 1);
      check("w_lo_waddr", rf_waddr, 31);
      check("w_lo_wdata", rf_wdata, 64'hAAAA_0000_AAAA_0001);
      check("w_lo_wmask", rf_wmask, 4'b1100);
      next_cycle();
      mid();
      check("w_hi_we", rf_we, 1);
      check("w_hi_waddr", rf_waddr, 0);
      check("w_hi_wdata", rf_wdata, 64'hBBBB_0000_BBBB_0002);
      check("w_hi_wmask", rf_wmask, 4'b0011);
      next_cycle();

      // Flags: dz on an uncommitted lane is ignored.
      set_entry(0, 5'd7, 4'b0001, 64'h5, '0, '0, 4'b0001, 4'b0100, '0);
      send();
      mid();
      check("flags_nv", fflags, 5'b10000);
      next_cycle();
      // Clear in the merge cycle: only the new nx survives.
      set_entry(0, 5'd8, 4'b0010, 64'h6, '0, '0, '0, '0, 4'b0010);
      fflags_clr = 1;
      send();
      fflags_clr = 0;
      mid();
      check("flags_clr_merge", fflags, 5'b00001);
      next_cycle();

      // Zero mask: no strobe, no flags, one cycle consumed.
      set_entry(0, 5'd9, 4'b0000, 64'hDEAD, '0, '0, 4'hF, 4'hF, 4'hF);
      in_of = 4'hF; in_uf = 4'hF;
      send();
      mid();
      check("z_we", rf_we, 0);
      check("z_fflags", fflags, 5'b00001);
      check("z_busy", busy, 1);
      next_cycle();
      mid();
      check("z_done", busy, 0);
      next_cycle();

      // Back-to-back wide entries with in_valid held high.
      clear_inputs();
      saw_block = 0;
      we_start  = we_seen;
      for (int i = 0; i < 8; i++) begin
         set_entry(1, 5'(i * 3), 4'hF, '0, 64'hA0 + 64'(i), 64'hB0 + 64'(i), '0, '0, '0);
         in_valid = 1;
         acc = 0;
         for (int w = 0; w < 20 && !acc; w++) begin
            mid();
            acc = in_ready;
            if (!acc) saw_block = 1;
            next_cycle();
         end
         if (!acc) check("push_timeout", 0, 1);
      end
      in_valid = 0;
      check("ready_dropped", saw_block, 1);
      drain("wide_drain");
      check("wide_writes", we_seen - we_start, 16);
      check("wide_queue_empty", q.size(), 0);

      // Reset while the high write of a wide entry is pending.
      set_entry(1, 5'd10, 4'hF, '0, 64'h1234, 64'h5678, 4'hF, '0, '0);
      send();
      rst = 1;
      mid();
      check("rst_lo_seen", rf_we, 1);
      check("rst_ready_low", in_ready, 0);
      next_cycle();
      mid();
      check("rst_no_hi", rf_we, 0);
      check("rst_waddr", rf_waddr, 0);
      check("rst_wdata", rf_wdata, 0);
      check("rst_wmask", rf_wmask, 0);
      check("rst_fflags", fflags, 0);
      check("rst_busy", busy, 0);
      rst = 0;
      next_cycle();
      mid();
      check("rst_ready_back", in_ready, 1);
      next_cycle();

      // Randomized traffic, occasional clears and resets.
      for (int c = 0; c < 600; c++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         in_wide      = 1'($urandom_range(0, 1));
         in_rd        = 5'($urandom);
         in_lane_mask = 4'($urandom);
         in_data      = {$urandom, $urandom};
         in_datai_0   = {$urandom, $urandom};
         in_datai_1   = {$urandom, $urandom};
         in_nv = 4'($urandom); in_nx = 4'($urandom); in_of = 4'($urandom);
         in_uf = 4'($urandom); in_dz = 4'($urandom);
         fflags_clr   = ($urandom_range(0, 15) == 0);
         rst          = ($urandom_range(0, 99) == 0);
         next_cycle();
      end
      clear_inputs();
      rst = 0;
      drain("random_drain");
      check("random_queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
